lru_age_tracker: RTL and testbench
==================================

// Module: lru_age_tracker
// PURPOSE
//  Parametrised least-recently-used tracker for NUM_WAYS ways. Each way has a saturating age that
//  advances on a prescaled tick. A way is touched by a rising edge on its access input.
//  On request, a sequential scan selects a victim and hands it over with a valid/ack handshake.
//  Successor of the fixed 5-way LED tracker; drives board LEDs and feeds the replacement controller.
// PARAMETERS
//  NUM_WAYS          5            number of tracked ways (>=2)
//  AGE_W             10           age counter width; saturates at 2**AGE_W-1
//  TICK_DIV          100_000_000  clk cycles per age tick (>=1)
//  EVICT_INVALIDATE  1            1: accepted victim is invalidated on ack; 0: victim left as is
// PORTS
//  clk          in   1         clock; all logic on posedge
//  rst          in   1         synchronous, active-high reset
//  access_in    in   NUM_WAYS  raw access levels (e.g. buttons), one bit per way
//  evict_req    in   1         level; victim search starts when high in IDLE
//  evict_ack    in   1         consumer accepts victim; meaningful only while evict_valid=1
//  evict_valid  out  1         victim output is valid; held until ack
//  victim       out  IDX_W     victim way index, IDX_W = $clog2(NUM_WAYS)
//  busy         out  1         high in SCAN or DONE
//  all_valid    out  1         all ways valid (registered)
//  led          out  NUM_WAYS  led[i]=1 while way i is invalid/free (registered)
// BEHAVIOUR
//  Reset:
//   - valid=0, ages=0, tick counter=0, edge-detect history=0.
//   - FSM=IDLE, evict_valid=0, victim=0, busy=0, all_valid=0, led=all ones.
//  Tick:
//   - counter runs 0..TICK_DIV-1; tick pulses 1 cycle when counter==TICK_DIV-1, then wraps to 0.
//   - TICK_DIV=1 means a tick every cycle.
//  Access:
//   - access_in is registered once; a touch is a rising edge (prev=0, cur=1).
//   - Touched way: valid<=1, age<=0. Multiple simultaneous touches are all applied.
//  Ageing:
//   - On tick, every valid, untouched way does age<=min(age+1, 2**AGE_W-1).
//   - Invalid ways stay at age 0.
//   - Touch and tick in the same cycle: the touch wins (age 0).
//  FSM IDLE -> SCAN -> DONE -> IDLE:
//   - IDLE: evict_req=1 -> snapshot valid[] and age[] into shadow regs, go to SCAN (i=0).
//   - SCAN: examines shadow way i, one per cycle, for NUM_WAYS cycles, then goes to DONE.
//     - Any invalid way present -> victim = lowest-index invalid way.
//     - Otherwise victim = maximum age; compare is strict >, so ties keep the lowest index.
//     - Live touches and ticks during SCAN update real state only, never the snapshot.
//   - DONE: evict_valid=1, victim stable.
//     - evict_ack=1 -> evict_valid<=0, go to IDLE.
//     - If EVICT_INVALIDATE, the ack also does valid[victim]<=0, age[victim]<=0.
//  Latency: evict_req sampled at edge t -> evict_valid high from edge t+NUM_WAYS+1.
//  Ack and touch of the victim way in the same cycle: the touch wins (way valid, age 0);
//   the handshake still completes.
//  evict_req held high after an ack: a new search starts on the next IDLE cycle, no bubble beyond IDLE.
//  rst asserted mid-SCAN/DONE: immediate return to reset state; no victim is issued.
//  led/all_valid: registered from the valid[] value of the previous cycle (1-cycle lag).
// STRUCTURE
//  - lru_pkg: IDX_W computation function, way_idx_t typedef, fsm_state_t enum {IDLE,SCAN,DONE}.
//  - Sub-module lru_tick_gen (TICK_DIV): prescaler; output is a 1-cycle tick pulse.
//  - Top holds edge detect, age/valid arrays, shadow regs, scan FSM, output regs.
// TESTING
//  All scenarios use NUM_WAYS=5, TICK_DIV=4, AGE_W=3 unless stated.
//  1 Reset then idle 20 cycles -> led=5'b11111, all_valid=0, evict_valid=0, busy=0.
//  2 No touches, pulse evict_req -> evict_valid rises 6 cycles after the sample edge, victim=0.
//    Then touch ways 0,2 and re-request -> victim=1.
//  3 Touch ways 2,0,4,1,3, each separated by one tick -> victim=2.
//    Ack with EVICT_INVALIDATE=1 -> led=5'b00100, all_valid=0.
//  4 Touch all ways in the same cycle, then wait 12 ticks -> all ages saturate at 7;
//    request -> victim=0 (tie resolves to lowest index).
//  5 Touch way 1 during SCAN -> victim is chosen from the snapshot.
//    Touch the victim in the same cycle as ack -> way stays valid, age 0, evict_valid drops.
//  6 Assert rst during SCAN cycle 3 -> next cycle busy=0, evict_valid=0, led=5'b11111;
//    no victim is ever issued.

Source files
------------

// File: rtl/lru_pkg.sv
// Shared definitions for the LRU age tracker: index-width helper, way index type, FSM states.
package lru_pkg;

  // Index width for n ways; never narrower than one bit.
  function automatic int calc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_NUM_WAYS = 5;
  localparam int DEF_IDX_W    = calc_idx_w(DEF_NUM_WAYS);

  typedef logic [DEF_IDX_W-1:0] way_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/lru_tick_gen.sv
// Age prescaler: emits a one-cycle tick every TICK_DIV clock cycles.
module lru_tick_gen #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int              CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: wrap to zero after the last count of the period.
  always_comb begin
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Tick is a decode of the counter register, so it is glitch-free and one cycle wide.
  assign tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/lru_age_tracker.sv
// LRU age tracker: per-way valid/age state, edge-detected touches, and a sequential
// victim scan over a snapshot with a valid/ack handover.
module lru_age_tracker
  import lru_pkg::*;
#(
  parameter int NUM_WAYS         = 5,
  parameter int AGE_W            = 10,
  parameter int TICK_DIV         = 100_000_000,
  parameter int EVICT_INVALIDATE = 1,
  localparam int IDX_W           = calc_idx_w(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_WAYS-1:0] access_in,
  input  logic                evict_req,
  input  logic                evict_ack,
  output logic                evict_valid,
  output logic [IDX_W-1:0]    victim,
  output logic                busy,
  output logic                all_valid,
  output logic [NUM_WAYS-1:0] led
);

  localparam int               SCAN_W    = $clog2(NUM_WAYS + 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(NUM_WAYS);
  localparam logic [AGE_W-1:0]  AGE_MAX   = {AGE_W{1'b1}};

  logic                tick_s;
  logic [NUM_WAYS-1:0] acc_q;
  logic [NUM_WAYS-1:0] acc_prev_q;
  logic [NUM_WAYS-1:0] touch_s;
  logic [NUM_WAYS-1:0] inval_s;
  logic                ack_fire_s;

  logic [NUM_WAYS-1:0] valid_q;
  logic [NUM_WAYS-1:0] valid_d;
  logic [AGE_W-1:0]    age_q [NUM_WAYS];
  logic [AGE_W-1:0]    age_d [NUM_WAYS];

  fsm_state_t          state_q;
  logic [SCAN_W-1:0]   scan_idx_q;
  logic [NUM_WAYS-1:0] sh_valid_q;
  logic [AGE_W-1:0]    sh_age_q [NUM_WAYS];
  logic                best_inv_q;
  logic [IDX_W-1:0]    best_idx_q;
  logic [AGE_W-1:0]    best_age_q;
  logic                cand_valid_s;
  logic [AGE_W-1:0]    cand_age_s;

  logic                evict_valid_q;
  logic [IDX_W-1:0]    victim_q;
  logic                busy_q;
  logic                all_valid_q;
  logic [NUM_WAYS-1:0] led_q;

  lru_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick_s)
  );

  // Register raw access levels once and keep one cycle of history for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      acc_prev_q <= '0;
    end else begin
      acc_q      <= access_in;
      acc_prev_q <= acc_q;
    end
  end

  assign touch_s    = acc_q & ~acc_prev_q;
  assign ack_fire_s = (state_q == DONE) && evict_ack;

  // Ways cleared by an accepted victim (only when invalidation on ack is enabled).
  always_comb begin
    inval_s = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      inval_s[i] = ack_fire_s && (EVICT_INVALIDATE != 0) && (victim_q == IDX_W'(i));
    end
  end

  // Next way state: touch beats invalidation, which beats ageing.
  always_comb begin
    valid_d = valid_q;
    age_d   = age_q;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (touch_s[i]) begin
        valid_d[i] = 1'b1;
        age_d[i]   = '0;
      end else if (inval_s[i]) begin
        valid_d[i] = 1'b0;
        age_d[i]   = '0;
      end else if (tick_s && valid_q[i] && (age_q[i] != AGE_MAX)) begin
        valid_d[i] = valid_q[i];
        age_d[i]   = age_q[i] + AGE_W'(1);
      end else begin
        valid_d[i] = valid_q[i];
        age_d[i]   = age_q[i];
      end
    end
  end

  // Way state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      age_q   <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      age_q   <= age_d;
    end
  end

  // Select the snapshot entry under examination in this SCAN cycle.
  always_comb begin
    cand_valid_s = 1'b1;
    cand_age_s   = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      cand_valid_s = (scan_idx_q == SCAN_W'(i)) ? sh_valid_q[i] : cand_valid_s;
      cand_age_s   = (scan_idx_q == SCAN_W'(i)) ? sh_age_q[i]   : cand_age_s;
    end
  end

  // Victim search FSM: snapshot, scan one way per cycle, then hold the victim until ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      scan_idx_q    <= '0;
      sh_valid_q    <= '0;
      sh_age_q      <= '{default: '0};
      best_inv_q    <= 1'b0;
      best_idx_q    <= '0;
      best_age_q    <= '0;
      evict_valid_q <= 1'b0;
      victim_q      <= '0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (evict_req) begin
            state_q    <= SCAN;
            scan_idx_q <= '0;
            sh_valid_q <= valid_q;
            sh_age_q   <= age_q;
            best_inv_q <= 1'b0;
            best_idx_q <= '0;
            best_age_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        SCAN: begin
          if (scan_idx_q == SCAN_LAST) begin
            state_q       <= DONE;
            evict_valid_q <= 1'b1;
            victim_q      <= best_idx_q;
          end else begin
            scan_idx_q <= scan_idx_q + SCAN_W'(1);
            // The first invalid way wins outright; otherwise strictly older ways replace the best.
            if (!cand_valid_s) begin
              if (!best_inv_q) begin
                best_inv_q <= 1'b1;
                best_idx_q <= scan_idx_q[IDX_W-1:0];
              end
            end else if (!best_inv_q && (cand_age_s > best_age_q)) begin
              best_idx_q <= scan_idx_q[IDX_W-1:0];
              best_age_q <= cand_age_s;
            end
          end
        end
        DONE: begin
          if (evict_ack) begin
            state_q       <= IDLE;
            evict_valid_q <= 1'b0;
            busy_q        <= 1'b0;
          end
        end
        default: begin
          state_q       <= IDLE;
          evict_valid_q <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  // Status outputs follow the previous cycle's valid vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q       <= {NUM_WAYS{1'b1}};
      all_valid_q <= 1'b0;
    end else begin
      led_q       <= ~valid_q;
      all_valid_q <= &valid_q;
    end
  end

  assign evict_valid = evict_valid_q;
  assign victim      = victim_q;
  assign busy        = busy_q;
  assign all_valid   = all_valid_q;
  assign led         = led_q;

endmodule

// File: tb/tb_lru_age_tracker.sv
// Randomised and directed bench for lru_age_tracker against a behavioural model.
module tb_lru_age_tracker;

  localparam int NW   = 5;
  localparam int AW   = 3;
  localparam int TD   = 4;
  localparam int EI   = 1;
  localparam int AMAX = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NW-1:0] access_in = '0;
  logic          evict_req = 1'b0;
  logic          evict_ack = 1'b0;
  logic          evict_valid;
  logic [2:0]    victim;
  logic          busy;
  logic          all_valid;
  logic [NW-1:0] led;

  lru_age_tracker #(
    .NUM_WAYS         (NW),
    .AGE_W            (AW),
    .TICK_DIV         (TD),
    .EVICT_INVALIDATE (EI)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .access_in   (access_in),
    .evict_req   (evict_req),
    .evict_ack   (evict_ack),
    .evict_valid (evict_valid),
    .victim      (victim),
    .busy        (busy),
    .all_valid   (all_valid),
    .led         (led)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  bit            m_valid [NW];
  int            m_age   [NW];
  logic [NW-1:0] m_h1, m_h2;     // access_in as seen at the previous two edges
  int            m_ncyc;         // edges since reset
  int            m_phase;        // 0 idle, 1 searching, 2 offering victim
  int            m_wait;
  int            m_snap;
  int            m_victim;
  bit            m_ev, m_busy, m_allv;
  logic [NW-1:0] m_led;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Lowest invalid way, else oldest way with ties going to the lowest index.
  function automatic int ref_victim();
    int best;
    for (int i = 0; i < NW; i++) begin
      if (!m_valid[i]) return i;
    end
    best = 0;
    for (int i = 1; i < NW; i++) begin
      if (m_age[i] > m_age[best]) best = i;
    end
    return best;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NW; i++) begin
      m_valid[i] = 1'b0;
      m_age[i]   = 0;
    end
    m_h1 = '0; m_h2 = '0; m_ncyc = 0; m_phase = 0; m_wait = 0; m_snap = 0;
    m_victim = 0; m_ev = 1'b0; m_busy = 1'b0; m_allv = 1'b0; m_led = '1;
  endtask

  task automatic model_step();
    logic [NW-1:0] touch;
    bit            tick, ackf;
    bit            old_v [NW];
    int            snap;
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < NW; i++) old_v[i] = m_valid[i];
      snap  = ref_victim();
      touch = m_h1 & ~m_h2;
      tick  = ((m_ncyc % TD) == TD - 1);
      m_ncyc++;
      ackf  = m_ev && evict_ack;
      for (int i = 0; i < NW; i++) begin
        if (touch[i]) begin
          m_valid[i] = 1'b1; m_age[i] = 0;
        end else if (ackf && EI != 0 && m_victim == i) begin
          m_valid[i] = 1'b0; m_age[i] = 0;
        end else if (tick && m_valid[i]) begin
          m_age[i] = (m_age[i] + 1 > AMAX) ? AMAX : m_age[i] + 1;
        end
      end
      m_h2 = m_h1;
      m_h1 = access_in;
      case (m_phase)
        0: if (evict_req) begin
             m_phase = 1; m_wait = NW; m_snap = snap; m_busy = 1'b1;
           end
        1: if (m_wait == 0) begin
             m_phase = 2; m_ev = 1'b1; m_victim = m_snap;
           end else begin
             m_wait--;
           end
        default: if (evict_ack) begin
             m_phase = 0; m_ev = 1'b0; m_busy = 1'b0;
           end
      endcase
      m_allv = 1'b1;
      for (int i = 0; i < NW; i++) begin
        m_led[i] = !old_v[i];
        if (!old_v[i]) m_allv = 1'b0;
      end
    end
  endtask

  // One clock: advance the model at the edge, then compare outputs just after it.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("evict_valid", evict_valid, m_ev);
    chk("busy", busy, m_busy);
    chk("led", led, m_led);
    chk("all_valid", all_valid, m_allv);
    if (m_ev) chk("victim", victim, m_victim);
  endtask

  task automatic do_reset();
    access_in = '0; evict_req = 1'b0; evict_ack = 1'b0;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic press(input logic [NW-1:0] mask);
    access_in = mask;
    cyc();
    access_in = '0;
    cyc();
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (evict_valid !== 1'b1 && lat < 30) begin
      cyc();
      lat++;
    end
  endtask

  task automatic request(input string tag, input int exp_victim);
    int lat;
    evict_req = 1'b1;
    cyc();
    evict_req = 1'b0;
    wait_valid(lat);
    chk({tag, "_latency"}, lat, NW + 1);
    chk({tag, "_victim"}, victim, exp_victim);
  endtask

  task automatic ack();
    evict_ack = 1'b1;
    cyc();
    evict_ack = 1'b0;
  endtask

  initial begin
    int lat;

    // 1: reset then idle
    do_reset();
    repeat (20) cyc();
    chk("s1_led", led, 5'b11111);
    chk("s1_all_valid", all_valid, 1'b0);
    chk("s1_evict_valid", evict_valid, 1'b0);
    chk("s1_busy", busy, 1'b0);

    // 2: empty tracker picks way 0; after touching 0 and 2, way 1 is the first free one
    do_reset();
    request("s2a", 0);
    ack();
    press(5'b00101);
    request("s2b", 1);
    ack();

    // 3: staggered touches one tick apart, oldest is way 2
    do_reset();
    press(5'b00100); repeat (TD - 2) cyc();
    press(5'b00001); repeat (TD - 2) cyc();
    press(5'b10000); repeat (TD - 2) cyc();
    press(5'b00010); repeat (TD - 2) cyc();
    press(5'b01000); repeat (TD - 2) cyc();
    request("s3", 2);
    ack();
    cyc();
    cyc();
    chk("s3_led", led, 5'b00100);
    chk("s3_all_valid", all_valid, 1'b0);

    // 4: all touched together, saturate, tie resolves to way 0
    do_reset();
    press(5'b11111);
    repeat (12 * TD) cyc();
    chk("s4_all_valid", all_valid, 1'b1);
    request("s4", 0);
    ack();

    // 5: touch during SCAN does not affect the snapshot; touch at ack wins
    do_reset();
    press(5'b11101);
    evict_req = 1'b1;
    cyc();
    evict_req = 1'b0;
    cyc();
    cyc();
    access_in = 5'b00010;
    cyc();
    access_in = '0;
    wait_valid(lat);
    chk("s5_victim", victim, 1);
    access_in = 5'b00010;
    cyc();
    access_in = '0;
    ack();
    chk("s5_evict_valid", evict_valid, 1'b0);
    cyc();
    cyc();
    chk("s5_led", led, 5'b00000);

    // 6: reset in the middle of a scan issues nothing
    do_reset();
    press(5'b11111);
    evict_req = 1'b1;
    cyc();
    evict_req = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("s6_busy", busy, 1'b0);
    chk("s6_evict_valid", evict_valid, 1'b0);
    chk("s6_led", led, 5'b11111);
    for (int k = 0; k < 15; k++) begin
      cyc();
      chk("s6_no_victim", evict_valid, 1'b0);
    end

    // Random traffic against the model
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 3) == 0) access_in = NW'($urandom);
      evict_req = ($urandom_range(0, 2) == 0);
      evict_ack = ($urandom_range(0, 1) == 0);
      rst       = ($urandom_range(0, 599) == 0);
      cyc();
    end
    rst = 1'b0; evict_req = 1'b0; evict_ack = 1'b0; access_in = '0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
